// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer around one shared 4-bit CLA (LS nibble first).
// Optional signed-overflow output o_Ovf is built only when CLA_SEQ_OVF_EN is defined.
`default_nettype none

module four_bit_CLA_adder_verilog (
    input  logic [3:0] i_A,
    input  logic [3:0] i_B,
    input  logic       i_Cin,
    output logic [3:0] o_Sum,
    output logic       o_Cout
);
    logic [3:0] w_g, w_p;
    logic [4:0] w_c;

    assign w_g    = i_A & i_B;
    assign w_p    = i_A ^ i_B;
    assign w_c[0] = i_Cin;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign o_Sum  = w_p ^ w_c[3:0];
    assign o_Cout = w_c[4];
endmodule

module cla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    output logic             o_Ready,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout
`ifdef CLA_SEQ_OVF_EN
   ,output logic             o_Ovf
`endif
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_work, w_work_nxt;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic [3:0]       w_nib_a, w_nib_b, w_nib_s;
    logic             w_nib_co;
    logic             w_last;

    assign w_nib_a = r_a[r_idx*4 +: 4];
    assign w_nib_b = r_b[r_idx*4 +: 4];
    assign w_last  = (r_idx == IW'(N - 1));

    four_bit_CLA_adder_verilog u_cla (
        .i_A    (w_nib_a),
        .i_B    (w_nib_b),
        .i_Cin  (r_carry),
        .o_Sum  (w_nib_s),
        .o_Cout (w_nib_co)
    );

    // Final nibble lands in the same edge that loads o_Sum, so merge it here.
    always_comb begin
        w_work_nxt                 = r_work;
        w_work_nxt[r_idx*4 +: 4]   = w_nib_s;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_Start) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_Ready = 1'b0;
        o_Busy  = 1'b0;
        o_Done  = 1'b0;
        case (r_state)
            S_IDLE:  o_Ready = 1'b1;
            S_RUN:   o_Busy  = 1'b1;
            S_DONE:  begin o_Busy = 1'b1; o_Done = 1'b1; end
            default: o_Ready = 1'b0;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            o_Sum   <= '0;
            o_Cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_Start) begin
                    r_a     <= i_A;
                    r_b     <= i_B;
                    r_carry <= i_Cin;
                    r_idx   <= '0;
                    r_work  <= '0;
                end
                S_RUN: begin
                    r_work  <= w_work_nxt;
                    r_carry <= w_nib_co;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        o_Sum  <= w_work_nxt;
                        o_Cout <= w_nib_co;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CLA_SEQ_OVF_EN
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            o_Ovf <= 1'b0;
        else if (r_state == S_RUN && w_last)
            o_Ovf <= (r_a[WIDTH-1] ~^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ w_work_nxt[WIDTH-1]);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cla_serial_add_ctrl.sv
// Randomized self-checking bench for cla_serial_add_ctrl (WIDTH=16) with a cycle-level reference model.
`timescale 1ns/1ps

module tb_cla_serial_add_ctrl;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk, rst_n, i_Start, i_Cin;
    logic [W-1:0] i_A, i_B;
    logic         o_Ready, o_Busy, o_Done, o_Cout;
    logic [W-1:0] o_Sum;
`ifdef CLA_SEQ_OVF_EN
    logic         o_Ovf;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    cla_serial_add_ctrl #(.WIDTH(W)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Start (i_Start),
        .i_A     (i_A),
        .i_B     (i_B),
        .i_Cin   (i_Cin),
        .o_Ready (o_Ready),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done),
        .o_Sum   (o_Sum),
        .o_Cout  (o_Cout)
`ifdef CLA_SEQ_OVF_EN
       ,.o_Ovf   (o_Ovf)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: phase counts edges since acceptance (0 = idle).
    int           m_phase;
    logic [W:0]   m_pend;
    logic         m_povf;
    logic [W-1:0] m_sum;
    logic         m_cout, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
            m_pend  <= '0; m_povf <= 1'b0;
        end else if (m_phase == 0) begin
            if (i_Start) begin
                m_phase <= 1;
                m_pend  <= {1'b0, i_A} + {1'b0, i_B} + {{W{1'b0}}, i_Cin};
                m_povf  <= (i_A[W-1] == i_B[W-1]) &&
                           (i_A[W-1] != ((i_A + i_B + {{(W-1){1'b0}}, i_Cin}) >> (W-1)));
            end
        end else if (m_phase == N + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
            if (m_phase == N) begin
                m_sum  <= m_pend[W-1:0];
                m_cout <= m_pend[W];
                m_ovf  <= m_povf;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", o_Ready, m_phase == 0);
            chk("cyc_busy",  o_Busy,  m_phase != 0);
            chk("cyc_done",  o_Done,  m_phase == N + 1);
            chk("cyc_sum",   o_Sum,   m_sum);
            chk("cyc_cout",  o_Cout,  m_cout);
`ifdef CLA_SEQ_OVF_EN
            chk("cyc_ovf",   o_Ovf,   m_ovf);
`endif
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output int lat);
        int n;
        n = 0;
        while (!o_Ready && n < 20) begin @(posedge clk); #2; n++; end
        chk("ready_wait", o_Ready, 1);
        i_A = a; i_B = b; i_Cin = c; i_Start = 1;
        @(posedge clk); #2;
        i_Start = 0;
        lat = 0;
        while (!o_Done && lat < 20) begin @(posedge clk); #2; lat++; end
        chk("done_seen", o_Done, 1);
    endtask

    initial begin
        int lat, m, d;
        logic [W-1:0] ra, rb, hs;
        logic rc, hc;
        logic [W:0] full;

        rst_n = 1; i_Start = 0; i_A = '0; i_B = '0; i_Cin = 0;
        #1 rst_n = 0;
        #1 chk_en = 1;
        @(posedge clk); #2;
        chk("rst_ready", o_Ready, 1);
        chk("rst_busy",  o_Busy,  0);
        chk("rst_sum",   o_Sum,   0);
        chk("rst_cout",  o_Cout,  0);
        @(posedge clk); #2;
        rst_n = 1;

        // Basic add
        run_op(16'h1234, 16'h4321, 1'b0, lat);
        chk("basic_latency", lat, N);
        chk("basic_sum",  o_Sum,  16'h5555);
        chk("basic_cout", o_Cout, 0);

        // Full ripple through every nibble
        run_op(16'hFFFF, 16'h0000, 1'b1, lat);
        chk("ripple_sum",  o_Sum,  16'h0000);
        chk("ripple_cout", o_Cout, 1);

        // Signed overflow cases
        run_op(16'h7FFF, 16'h0001, 1'b0, lat);
        chk("ovf1_sum",  o_Sum,  16'h8000);
        chk("ovf1_cout", o_Cout, 0);
`ifdef CLA_SEQ_OVF_EN
        chk("ovf1_ovf",  o_Ovf,  1);
`endif
        run_op(16'hFFFF, 16'h0001, 1'b0, lat);
        chk("ovf2_sum",  o_Sum,  16'h0000);
        chk("ovf2_cout", o_Cout, 1);
`ifdef CLA_SEQ_OVF_EN
        chk("ovf2_ovf",  o_Ovf,  0);
`endif

        // Start held high while busy
        @(posedge clk); #2;
        i_A = 16'h00FF; i_B = 16'h0001; i_Cin = 0; i_Start = 1;
        @(posedge clk); #2;
        i_A = 16'hAAAA;
        m = 0;
        while (!o_Ready && m < 20) begin
            @(posedge clk); #2; m++;
            if (o_Done) chk("busy_first_sum", o_Sum, 16'h0100);
        end
        chk("busy_ready_gap", m, N + 1);
        @(posedge clk); #2;
        chk("busy_second_accept", o_Busy, 1);
        i_Start = 0;
        lat = 0;
        while (!o_Done && lat < 20) begin @(posedge clk); #2; lat++; end
        chk("busy_second_sum", o_Sum, 16'hAAAB);

        // Reset in the middle of RUN
        run_op(16'hF0F0, 16'h0F0F, 1'b0, lat);
        chk("pre_rst_sum", o_Sum, 16'hFFFF);
        @(posedge clk); #2;
        i_A = 16'hF0F0; i_B = 16'h0F0F; i_Start = 1;
        @(posedge clk); #2;
        i_Start = 0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("midrst_busy",  o_Busy,  0);
        chk("midrst_ready", o_Ready, 1);
        chk("midrst_sum",   o_Sum,   0);
        chk("midrst_done",  o_Done,  0);
        @(posedge clk); #2;
        rst_n = 1;
        d = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #2; if (o_Done) d++; end
        chk("midrst_no_done", d, 0);
        run_op(16'h0001, 16'h0001, 1'b0, lat);
        chk("post_rst_sum", o_Sum, 16'h0002);

        // Result hold while inputs toggle
        @(posedge clk); #2;
        hs = o_Sum; hc = o_Cout;
        for (int i = 0; i < 20; i++) begin
            i_A = W'($urandom); i_B = W'($urandom);
            @(posedge clk); #2;
            chk("hold_sum",  o_Sum,  hs);
            chk("hold_cout", o_Cout, hc);
            chk("hold_done", o_Done, 0);
        end

        // Randomized operations with random gaps
        for (int t = 0; t < 40; t++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (t % 8 == 0) rb = ~ra;
            run_op(ra, rb, rc, lat);
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            chk("rand_latency", lat, N);
            chk("rand_sum",  o_Sum,  full[W-1:0]);
            chk("rand_cout", o_Cout, full[W]);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin @(posedge clk); #2; end
        end

        @(posedge clk); #2;
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
